// File: rtl/rope_pkg.sv
// Shared phase codes, FSM states, fixed-point constants and core group masks for the rope frame sequencer.
// Pure definitions, no state and no flow control of its own.
package rope_pkg;

   localparam int FRAC_BITS = 12;
   localparam int WORD      = 32;
   localparam int PIX_BITS  = 10;
   localparam int MAX_CORES = 32;

   typedef enum logic [1:0] {
      PH_IDLE = 2'd0,
      PH_INT  = 2'd1,
      PH_EVEN = 2'd2,
      PH_ODD  = 2'd3
   } phase_e;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_INT_ISSUE  = 3'd1,
      ST_INT_WAIT   = 3'd2,
      ST_EVEN_ISSUE = 3'd3,
      ST_EVEN_WAIT  = 3'd4,
      ST_ODD_ISSUE  = 3'd5,
      ST_ODD_WAIT   = 3'd6,
      ST_SNAPSHOT   = 3'd7
   } state_e;

   // Red-black groups: neighbouring cores always land in different groups.
   function automatic logic [MAX_CORES-1:0] even_mask(input int cores);
      logic [MAX_CORES-1:0] m;
      m = '0;
      for (int i = 0; i < MAX_CORES; i++)
         m[i] = (i < cores) && (i % 2 == 0);
      return m;
   endfunction

   function automatic logic [MAX_CORES-1:0] odd_mask(input int cores);
      logic [MAX_CORES-1:0] m;
      m = '0;
      for (int i = 0; i < MAX_CORES; i++)
         m[i] = (i < cores) && (i % 2 == 1);
      return m;
   endfunction

endpackage

// File: rtl/rope_done_tracker.sv
// Pending-core register for one phase: load the group mask, strike cores as their done pulses arrive.
// All-done is combinational on the current done pulses; done bits outside the pending set are ignored.
module rope_done_tracker #(
   parameter int CORES = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_load,
   input  logic [CORES-1:0] i_load_mask,
   input  logic             i_track,
   input  logic [CORES-1:0] i_done,
   output logic             o_all_done
);

   logic [CORES-1:0] r_pending;
   logic [CORES-1:0] w_remaining;

   assign w_remaining = r_pending & ~i_done;
   assign o_all_done  = (w_remaining == '0);

   always_ff @(posedge clk) begin
      if (reset)
         r_pending <= '0;
      else if (i_load)
         r_pending <= i_load_mask;
      else if (i_track)
         r_pending <= w_remaining;
   end

endmodule

// File: rtl/rope_step_sequencer.sv
// Per-frame controller: latch clamped mouse, run integrate then ITERATIONS red-black relaxation passes, pulse snapshot.
// Frame start to ISSUE is 1 cycle; phases wait indefinitely on core_done; ticks arriving while busy are dropped and flagged.
module rope_step_sequencer
   import rope_pkg::*;
#(
   parameter int CORES      = 4,
   parameter int ITERATIONS = 8,
   parameter int MAX_X      = 639,
   parameter int MAX_Y      = 479
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                frame_tick,
   input  logic [PIX_BITS-1:0] in_mouse_x,
   input  logic [PIX_BITS-1:0] in_mouse_y,
   input  logic [CORES-1:0]    core_done,
   output logic [CORES-1:0]    core_start,
   output logic [1:0]          core_phase,
   output logic [WORD-1:0]     mouse_x,
   output logic [WORD-1:0]     mouse_y,
   output logic                snapshot,
   output logic                busy,
   output logic                overrun
);

   localparam int                  IW        = $clog2(ITERATIONS + 1);
   localparam logic [IW-1:0]       LAST_PASS = IW'(ITERATIONS - 1);
   localparam logic [CORES-1:0]    ALL_MASK  = '1;
   localparam logic [CORES-1:0]    EVEN_MASK = CORES'(even_mask(CORES));
   localparam logic [CORES-1:0]    ODD_MASK  = CORES'(odd_mask(CORES));
   localparam logic [PIX_BITS-1:0] CLAMP_X   = PIX_BITS'(MAX_X);
   localparam logic [PIX_BITS-1:0] CLAMP_Y   = PIX_BITS'(MAX_Y);
   localparam int                  PAD       = WORD - PIX_BITS - FRAC_BITS;

   state_e              r_state;
   phase_e              r_phase;
   logic [CORES-1:0]    r_core_start;
   logic [IW-1:0]       r_iter;
   logic [WORD-1:0]     r_mouse_x;
   logic [WORD-1:0]     r_mouse_y;
   logic                r_snapshot;
   logic                r_busy;
   logic                r_overrun;

   logic                w_all_done;
   logic                w_load;
   logic                w_track;
   logic                w_pass_end;
   logic [PIX_BITS-1:0] w_clamp_x;
   logic [PIX_BITS-1:0] w_clamp_y;

   assign w_load  = (r_state == ST_INT_ISSUE) || (r_state == ST_EVEN_ISSUE) || (r_state == ST_ODD_ISSUE);
   assign w_track = (r_state == ST_INT_WAIT)  || (r_state == ST_EVEN_WAIT)  || (r_state == ST_ODD_WAIT);

   // A single core has no odd group, so the even wait closes the pass on its own.
   assign w_pass_end = w_all_done &&
                       ((r_state == ST_ODD_WAIT) || ((r_state == ST_EVEN_WAIT) && (CORES == 1)));

   assign w_clamp_x = (in_mouse_x > CLAMP_X) ? CLAMP_X : in_mouse_x;
   assign w_clamp_y = (in_mouse_y > CLAMP_Y) ? CLAMP_Y : in_mouse_y;

   // core_start is non-zero only in ISSUE cycles and then equals the group mask.
   rope_done_tracker #(
      .CORES (CORES)
   ) u_done_tracker (
      .clk         (clk),
      .reset       (reset),
      .i_load      (w_load),
      .i_load_mask (r_core_start),
      .i_track     (w_track),
      .i_done      (core_done),
      .o_all_done  (w_all_done)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_phase      <= PH_IDLE;
         r_core_start <= '0;
         r_iter       <= '0;
         r_mouse_x    <= '0;
         r_mouse_y    <= '0;
         r_snapshot   <= 1'b0;
         r_busy       <= 1'b0;
         r_overrun    <= 1'b0;
      end else begin
         r_core_start <= '0;
         r_snapshot   <= 1'b0;
         if (frame_tick && (r_state != ST_IDLE))
            r_overrun <= 1'b1;

         case (r_state)
            ST_IDLE: begin
               if (frame_tick) begin
                  r_mouse_x    <= {{PAD{1'b0}}, w_clamp_x, {FRAC_BITS{1'b0}}};
                  r_mouse_y    <= {{PAD{1'b0}}, w_clamp_y, {FRAC_BITS{1'b0}}};
                  r_busy       <= 1'b1;
                  r_iter       <= '0;
                  r_core_start <= ALL_MASK;
                  r_phase      <= PH_INT;
                  r_state      <= ST_INT_ISSUE;
               end
            end
            ST_INT_ISSUE:  r_state <= ST_INT_WAIT;
            ST_EVEN_ISSUE: r_state <= ST_EVEN_WAIT;
            ST_ODD_ISSUE:  r_state <= ST_ODD_WAIT;
            ST_INT_WAIT: begin
               if (w_all_done) begin
                  r_core_start <= EVEN_MASK;
                  r_phase      <= PH_EVEN;
                  r_state      <= ST_EVEN_ISSUE;
               end
            end
            ST_EVEN_WAIT, ST_ODD_WAIT: begin
               if (w_pass_end) begin
                  if (r_iter == LAST_PASS) begin
                     r_snapshot <= 1'b1;
                     r_phase    <= PH_IDLE;
                     r_state    <= ST_SNAPSHOT;
                  end else begin
                     r_iter       <= r_iter + 1'b1;
                     r_core_start <= EVEN_MASK;
                     r_phase      <= PH_EVEN;
                     r_state      <= ST_EVEN_ISSUE;
                  end
               end else if (w_all_done && (r_state == ST_EVEN_WAIT)) begin
                  r_core_start <= ODD_MASK;
                  r_phase      <= PH_ODD;
                  r_state      <= ST_ODD_ISSUE;
               end
            end
            ST_SNAPSHOT: begin
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign core_start = r_core_start;
   assign core_phase = r_phase;
   assign mouse_x    = r_mouse_x;
   assign mouse_y    = r_mouse_y;
   assign snapshot   = r_snapshot;
   assign busy       = r_busy;
   assign overrun    = r_overrun;

endmodule

// File: tb/tb_rope_step_sequencer.sv
// Bench for rope_step_sequencer: random core latencies and mouse values against a per-phase timing model,
// plus a one-core, two-pass instance for the degenerate red-black case.
module tb_rope_step_sequencer;

   localparam int NC = 4;
   localparam int NI = 8;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        frame_tick;
   logic [9:0]  in_mouse_x;
   logic [9:0]  in_mouse_y;
   logic [NC-1:0] core_done;
   logic [NC-1:0] core_start;
   logic [1:0]  core_phase;
   logic [31:0] mouse_x;
   logic [31:0] mouse_y;
   logic        snapshot;
   logic        busy;
   logic        overrun;

   logic        frame_tick1;
   logic [0:0]  core_done1;
   logic [0:0]  core_start1;
   logic [1:0]  core_phase1;
   logic [31:0] mouse_x1;
   logic [31:0] mouse_y1;
   logic        snapshot1;
   logic        busy1;
   logic        overrun1;

   int          n_checks = 0;
   int          n_pass   = 0;
   int          cyc      = 0;
   int          due[NC];
   logic [NC-1:0] grp;
   logic        exp_ovr;

   rope_step_sequencer dut (
      .clk        (clk),
      .reset      (reset),
      .frame_tick (frame_tick),
      .in_mouse_x (in_mouse_x),
      .in_mouse_y (in_mouse_y),
      .core_done  (core_done),
      .core_start (core_start),
      .core_phase (core_phase),
      .mouse_x    (mouse_x),
      .mouse_y    (mouse_y),
      .snapshot   (snapshot),
      .busy       (busy),
      .overrun    (overrun)
   );

   rope_step_sequencer #(.CORES(1), .ITERATIONS(2)) dut1 (
      .clk        (clk),
      .reset      (reset),
      .frame_tick (frame_tick1),
      .in_mouse_x (in_mouse_x),
      .in_mouse_y (in_mouse_y),
      .core_done  (core_done1),
      .core_start (core_start1),
      .core_phase (core_phase1),
      .mouse_x    (mouse_x1),
      .mouse_y    (mouse_y1),
      .snapshot   (snapshot1),
      .busy       (busy1),
      .overrun    (overrun1)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
   endtask

   function automatic logic [31:0] clampq(input int v, input int m);
      int c;
      c = (v > m) ? m : v;
      return 32'(c) << 12;
   endfunction

   // Start k of a frame: integrate, then even/odd alternating.
   function automatic logic [31:0] exp_mask(input int k);
      if (k == 0)      return 32'hF;
      else if (k % 2)  return 32'h5;
      else             return 32'hA;
   endfunction

   function automatic logic [31:0] exp_phase(input int k);
      if (k == 0)      return 32'd1;
      else if (k % 2)  return 32'd2;
      else             return 32'd3;
   endfunction

   task automatic next_cycle();
      @(negedge clk);
      cyc++;
   endtask

   task automatic drive_dues();
      for (int i = 0; i < NC; i++)
         core_done[i] = (due[i] == cyc);
   endtask

   task automatic idle(input int n);
      for (int j = 0; j < n; j++) begin
         next_cycle();
         check_eq("idle_busy", busy, 0);
         check_eq("idle_start", core_start, 0);
         drive_dues();
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      next_cycle();
      check_eq("rst_start", core_start, 0);
      check_eq("rst_phase", core_phase, 0);
      check_eq("rst_mx", mouse_x, 0);
      check_eq("rst_my", mouse_y, 0);
      check_eq("rst_snap", snapshot, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_ovr", overrun, 0);
      exp_ovr = 1'b0;
      reset   = 1'b0;
      core_done = '0;
   endtask

   // mode 0: every done 1 cycle after start; 1: random latencies + spurious dones outside the group;
   // 2: core 3 late in integrate, spurious core 1 during the first even wait; 3: reset inside pass rst_k's wait.
   task automatic run_frame(input int mx, input int my, input int mode, input int ovr_at, input int rst_k);
      int t0, k, exp_issue, d, maxd, rst_cyc;
      bit seen_snap, aborted;
      logic [31:0] ex, ey;
      logic [NC-1:0] spur;
      ex = clampq(mx, 639);
      ey = clampq(my, 479);
      in_mouse_x = 10'(mx);
      in_mouse_y = 10'(my);
      frame_tick = 1'b1;
      core_done  = '0;
      t0 = cyc; k = 0; exp_issue = t0 + 1; rst_cyc = -1;
      seen_snap = 1'b0; aborted = 1'b0;
      for (int n = 0; n < 400 && !seen_snap && !aborted; n++) begin
         next_cycle();
         if (cyc == t0 + 1) begin
            check_eq("busy_on", busy, 1);
            check_eq("mouse_x", mouse_x, ex);
            check_eq("mouse_y", mouse_y, ey);
         end
         if (rst_cyc >= 0 && cyc == rst_cyc + 1) begin
            check_eq("abort_start", core_start, 0);
            check_eq("abort_phase", core_phase, 0);
            check_eq("abort_mx", mouse_x, 0);
            check_eq("abort_busy", busy, 0);
            check_eq("abort_snap", snapshot, 0);
            check_eq("abort_ovr", overrun, 0);
            exp_ovr = 1'b0;
            aborted = 1'b1;
         end else if (core_start != '0) begin
            check_eq(mode == 2 && k == 1 ? "even_after_core3" : "issue_cyc", cyc, exp_issue);
            check_eq("start_mask", core_start, exp_mask(k));
            check_eq("issue_phase", core_phase, exp_phase(k));
            check_eq("busy_run", busy, 1);
            maxd = 0;
            for (int i = 0; i < NC; i++) begin
               if (core_start[i]) begin
                  if (mode == 1)                     d = $urandom_range(1, 4);
                  else if (mode == 2 && k == 0)      d = (i == 3) ? 5 : 1;
                  else if (mode == 2 && k == 1)      d = 2;
                  else if (mode == 3 && k == rst_k)  d = 3;
                  else                               d = 1;
                  due[i] = cyc + d;
                  if (d > maxd) maxd = d;
               end
            end
            if (mode == 3 && k == rst_k) rst_cyc = cyc + 1;
            exp_issue = cyc + maxd + 1;
            grp = core_start;
            k++;
         end
         if (snapshot && !aborted) begin
            check_eq("snap_cyc", cyc, exp_issue);
            check_eq("n_starts", k, 1 + 2 * NI);
            check_eq("snap_phase", core_phase, 0);
            check_eq("snap_busy", busy, 1);
            check_eq("snap_mx_hold", mouse_x, ex);
            check_eq("snap_my_hold", mouse_y, ey);
            if (mode == 0) check_eq("snap_t35", cyc - t0, 35);
            seen_snap = 1'b1;
         end
         frame_tick = (ovr_at > 0) && (cyc == t0 + ovr_at);
         if (frame_tick) exp_ovr = 1'b1;
         if (rst_cyc >= 0) reset = (cyc == rst_cyc);
         in_mouse_x = 10'($urandom);
         in_mouse_y = 10'($urandom);
         if (mode == 1)                 spur = NC'($urandom) & ~grp;
         else if (mode == 2 && k == 2)  spur = 4'b0010;
         else                           spur = '0;
         for (int i = 0; i < NC; i++)
            core_done[i] = (due[i] == cyc) | spur[i];
      end
      if (!aborted) begin
         check_eq("snap_seen", seen_snap, 1);
         next_cycle();
         check_eq("busy_off", busy, 0);
         check_eq("snap_pulse", snapshot, 0);
         check_eq("ovr_sticky", overrun, exp_ovr);
         drive_dues();
      end
   endtask

   task automatic run_small();
      int t0, nph;
      bit seen;
      logic [1:0] ph[$];
      logic [0:0] prev;
      frame_tick1 = 1'b1;
      t0 = cyc; seen = 1'b0; prev = '0;
      for (int n = 0; n < 100 && !seen; n++) begin
         next_cycle();
         if (core_start1 != '0) ph.push_back(core_phase1);
         check_eq("small_no_odd", core_phase1 == 2'd3, 0);
         if (snapshot1) begin
            nph = ph.size();
            check_eq("small_nph", nph, 3);
            if (nph == 3) begin
               check_eq("small_ph0", ph[0], 1);
               check_eq("small_ph1", ph[1], 2);
               check_eq("small_ph2", ph[2], 2);
            end
            check_eq("small_snap_t", cyc - t0, 7);
            seen = 1'b1;
         end
         frame_tick1 = 1'b0;
         core_done1  = prev;
         prev        = core_start1;
      end
      check_eq("small_seen", seen, 1);
      next_cycle();
      check_eq("small_busy_off", busy1, 0);
      check_eq("small_ovr", overrun1, 0);
   endtask

   initial begin
      reset = 1'b1; frame_tick = 1'b0; frame_tick1 = 1'b0;
      core_done = '0; core_done1 = '0; in_mouse_x = '0; in_mouse_y = '0;
      grp = '0; exp_ovr = 1'b0;
      for (int i = 0; i < NC; i++) due[i] = -100;
      repeat (2) next_cycle();
      do_reset();
      idle(2);

      run_frame(100, 50, 0, 0, -1);
      run_frame(1000, 600, 0, 0, -1);
      idle(1);
      run_frame(320, 240, 2, 0, -1);
      run_frame(12, 700, 0, 10, -1);
      idle(2);
      run_frame(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), 1, 0, -1);
      do_reset();
      run_frame(500, 400, 3, 0, 7);
      idle(3);
      run_frame(639, 479, 0, 0, -1);
      for (int f = 0; f < 6; f++)
         run_frame(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), 1, 0, -1);
      idle(2);
      run_small();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
